// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: state encoding, sizing constants
// and the direction rule used when a single filtered bit changes.
package quad_pkg;

   localparam int FILT_LEN_DEF = 4;
   localparam int ERR_CNT_W    = 8;
   localparam int INIT_CYCLES  = 3;

   // Low two bits of every Q state equal the filtered {a,b} it represents.
   typedef enum logic [2:0] {
      Q00  = 3'b000,
      Q01  = 3'b001,
      Q10  = 3'b010,
      Q11  = 3'b011,
      INIT = 3'b100
   } state_t;

   // Up order is 00->10->11->01->00: on every up step the new B equals the old A.
   function automatic logic is_up(input logic [1:0] prev_ab, input logic [1:0] new_ab);
      return new_ab[0] == prev_ab[1];
   endfunction

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchronizer followed by a stability filter: the filtered value only
// follows the synchronized input after FILT_LEN consecutive differing cycles.
module sync_filter #(
   parameter int FILT_LEN = 4
) (
   input  logic clock,
   input  logic clr_n,
   input  logic din,
   input  logic load,
   output logic sync,
   output logic filt
);

   localparam logic [3:0] LAST = 4'(FILT_LEN - 1);

   logic meta_reg;
   logic sync_reg;
   logic filt_reg;
   logic [3:0] cnt_reg;

   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
         filt_reg <= 1'b0;
         cnt_reg  <= 4'd0;
      end else begin
         meta_reg <= din;
         sync_reg <= meta_reg;
         // load bypasses the filter so start-up begins from the true pin level
         if (load) begin
            filt_reg <= sync_reg;
            cnt_reg  <= 4'd0;
         end else if (sync_reg == filt_reg) begin
            cnt_reg <= 4'd0;
         end else if (cnt_reg == LAST) begin
            filt_reg <= sync_reg;
            cnt_reg  <= 4'd0;
         end else begin
            cnt_reg <= cnt_reg + 4'd1;
         end
      end
   end

   assign sync = sync_reg;
   assign filt = filt_reg;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filters A/B/index, tracks the quadrature phase and emits
// step/direction, index-driven clear and illegal-transition error pulses.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic                 clock,
   input  logic                 clr_n,
   input  logic                 enc_a,
   input  logic                 enc_b,
   input  logic                 enc_idx,
   input  logic                 idx_en,
   output logic                 step,
   output logic                 mode,
   output logic                 clr,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic [2:0] pins;
   logic [2:0] sync_v;
   logic [2:0] filt_v;
   logic       load;

   assign pins = {enc_idx, enc_b, enc_a};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_chan
         sync_filter #(.FILT_LEN(FILT_LEN)) u_sf (
            .clock (clock),
            .clr_n (clr_n),
            .din   (pins[gi]),
            .load  (load),
            .sync  (sync_v[gi]),
            .filt  (filt_v[gi])
         );
      end
   endgenerate

   logic [1:0] ab_filt;
   logic [1:0] ab_sync;
   assign ab_filt = {filt_v[0], filt_v[1]};
   assign ab_sync = {sync_v[0], sync_v[1]};

   state_t               state_reg, state_next;
   logic [1:0]           init_reg, init_next;
   logic                 idx_prev_reg, idx_prev_next;
   logic                 step_reg, step_next;
   logic                 mode_reg, mode_next;
   logic                 clr_reg, clr_next;
   logic                 err_reg, err_next;
   logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;
   logic [1:0]           diff;

   assign load = (state_reg == INIT);
   assign diff = ab_filt ^ state_reg[1:0];

   always_comb begin
      state_next    = state_reg;
      init_next     = init_reg;
      step_next     = 1'b0;
      mode_next     = mode_reg;
      clr_next      = 1'b0;
      err_next      = 1'b0;
      err_cnt_next  = err_cnt_reg;
      idx_prev_next = filt_v[2];
      if (state_reg == INIT) begin
         // filters load from the sync outputs this cycle, so pick the state from them too
         idx_prev_next = sync_v[2];
         if (init_reg == 2'(INIT_CYCLES - 1)) begin
            state_next = state_t'({1'b0, ab_sync});
         end else begin
            init_next = init_reg + 2'd1;
         end
      end else begin
         if (diff != 2'b00) begin
            state_next = state_t'({1'b0, ab_filt});
            if (diff[0] ^ diff[1]) begin
               step_next = 1'b1;
               mode_next = is_up(state_reg[1:0], ab_filt);
            end else begin
               err_next = 1'b1;
               if (err_cnt_reg != {ERR_CNT_W{1'b1}}) begin
                  err_cnt_next = err_cnt_reg + 1'b1;
               end
            end
         end
         if (idx_en && filt_v[2] && !idx_prev_reg &&
             (state_reg == Q00 || state_next == Q00)) begin
            clr_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         state_reg    <= INIT;
         init_reg     <= 2'd0;
         idx_prev_reg <= 1'b0;
         step_reg     <= 1'b0;
         mode_reg     <= 1'b1;
         clr_reg      <= 1'b0;
         err_reg      <= 1'b0;
         err_cnt_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         init_reg     <= init_next;
         idx_prev_reg <= idx_prev_next;
         step_reg     <= step_next;
         mode_reg     <= mode_next;
         clr_reg      <= clr_next;
         err_reg      <= err_next;
         err_cnt_reg  <= err_cnt_next;
      end
   end

   assign step    = step_reg;
   assign mode    = mode_reg;
   assign clr     = clr_reg;
   assign err     = err_reg;
   assign err_cnt = err_cnt_reg;

endmodule
